imem_resp: RTL and testbench
============================

IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-address bits actually decoded (memory depth 2**ADDR_W words of 16 bits).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted between request acceptance and response (legal 0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  fetch/datapath side presents an access.
REQ-006 SHALL have port req_ready  output  1  responder can accept an access this cycle.
REQ-007 SHALL have port req_addr  input  16  LC3 word address (the fetch unit's addr_out).
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read (the fetch unit's wea_out).
REQ-009 SHALL have port req_wdata  input  16  write data, ignored on reads.
REQ-010 SHALL have port rsp_valid  output  1  single-cycle pulse marking completion.
REQ-011 SHALL have port rsp_data  output  16  read data, or echoed write data on writes.
REQ-012 SHALL have port rsp_err  output  1  out-of-range flag, valid with rsp_valid.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0.
REQ-015 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_addr, req_we and req_wdata SHALL be captured at that edge.
REQ-016 On acceptance, the FSM SHALL go to WAIT with the counter loaded to WAIT_CYCLES-1, or directly to RESP when WAIT_CYCLES=0.
REQ-017 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-018 rsp_valid SHALL be 1 for exactly the one cycle spent in RESP, i.e. WAIT_CYCLES+1 cycles after the acceptance edge; RESP SHALL always return to IDLE.
REQ-019 Reads SHALL return mem[req_addr[ADDR_W-1:0]] on rsp_data.
REQ-020 Writes SHALL update the memory at the RESP edge and SHALL echo the captured wdata on rsp_data.
REQ-021 A read that immediately follows a write to the same address SHALL return the new data.
REQ-022 rsp_data SHALL hold its last value outside RESP; rsp_err SHALL be 0 outside RESP.
REQ-023 req_valid held high while req_ready=0 SHALL be ignored and not queued; a new acceptance SHALL first be possible in the cycle after RESP (back-to-back throughput: one access per WAIT_CYCLES+2 cycles).
REQ-024 Input changes after acceptance SHALL NOT affect the access in flight.

Reset
REQ-025 While rst=1, the FSM SHALL be in IDLE, the counter 0, and req_ready, rsp_valid, rsp_data and rsp_err SHALL all be 0, regardless of clk.
REQ-026 req_ready SHALL rise to 1 in the first cycle after rst deasserts.
REQ-027 Asserting rst mid-access SHALL abort the access, SHALL suppress both the write and the response, and SHALL leave memory contents unchanged (memory itself is not reset).

Configuration
REQ-028 With macro IMEM_BOUNDS_CHECK_EN defined, any request with req_addr[15:ADDR_W] nonzero SHALL complete with normal timing, rsp_err=1, rsp_data=0 and no memory write.
REQ-029 Without IMEM_BOUNDS_CHECK_EN, upper address bits SHALL be ignored (aliasing), and rsp_err SHALL be tied to 0.

Structure
REQ-030 Shared package lc3_mem_pkg SHALL hold WORD_W=16, the FSM state enum, and the WAIT_CYCLES/ADDR_W default constants.
REQ-031 Storage SHALL be a sub-module imem_array (synchronous-write, combinational-read, 2**ADDR_W x 16); the FSM and counter SHALL reside in imem_resp.

Verification
REQ-032 Reset: hold rst=1 for 5 cycles then release -> during reset all outputs are 0; the next cycle req_ready=1 and rsp_valid=0.
REQ-033 Write then read (WAIT_CYCLES=2): write 0x3000<-0x1234, then read 0x3000 (ADDR_W=16 build) -> each rsp_valid arrives exactly 3 cycles after acceptance; read rsp_data=0x1234 with rsp_err=0.
REQ-034 Zero wait (WAIT_CYCLES=0): read addr 0x0005 -> rsp_valid 1 cycle after acceptance; req_ready is low for exactly that cycle.
REQ-035 Held request: req_valid held high for 10 cycles with a fixed read address -> exactly 2 responses with WAIT_CYCLES=2 (one per 4 cycles, accepted at cycles 0, 4, 8 -> 3 acceptances if still valid at cycle 8); no duplicate pulse occurs within one access.
REQ-036 Reset mid-access: accept a write of 0xBEEF to addr 0x0010, assert rst during WAIT -> no rsp_valid; a later read of 0x0010 returns the prior contents.
REQ-037 Bounds (IMEM_BOUNDS_CHECK_EN, ADDR_W=8): write to 0x0100 -> rsp_err=1 and rsp_data=0; a subsequent read of 0x0000 is unchanged. Without the macro, the same write aliases to 0x0000.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared word width, default sizing and responder FSM state encoding
package lc3_mem_pkg;
    localparam int WORD_W          = 16;
    localparam int ADDR_W_DEF      = 8;
    localparam int WAIT_CYCLES_DEF = 2;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/imem_array.sv
// imem_array: 2**ADDR_W x WORD_W storage, synchronous write, combinational read, not reset
module imem_array import lc3_mem_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [1 << ADDR_W];
    // write port
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
    assign rdata = mem[addr];
endmodule

// File: rtl/imem_resp.sv
// imem_resp: single-outstanding instruction-memory responder with WAIT_CYCLES wait states
// optional IMEM_BOUNDS_CHECK_EN flags accesses whose upper address bits are nonzero
module imem_resp import lc3_mem_pkg::*; #(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WORD_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_err
);
    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic [WORD_W-1:0] cap_addr, cap_wdata, rd_data, rsp_live, rsp_hold;
    logic              cap_we, accept, oob;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = state == RESP;

`ifdef IMEM_BOUNDS_CHECK_EN
    assign oob = (cap_addr >> ADDR_W) != '0;
`else
    logic unused_hi;
    assign unused_hi = |(cap_addr >> ADDR_W);
    assign oob       = 1'b0;
`endif

    assign rsp_live = oob ? '0 : cap_we ? cap_wdata : rd_data;
    assign rsp_data = rsp_valid ? rsp_live : rsp_hold;
    assign rsp_err  = rsp_valid && oob;

    // next-state: IDLE -> WAIT/RESP on accept, WAIT -> RESP when count expires, RESP -> IDLE
    always_comb begin
        state_nx = state;
        if (state == IDLE && accept)
            state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
        else if (state == WAIT && cnt == 4'd0)
            state_nx = RESP;
        else if (state == RESP)
            state_nx = IDLE;
    end

    // state register; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    // request capture and wait-state counter
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt       <= '0;
            cap_addr  <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
        end else if (accept) begin
            cnt       <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
            cap_addr  <= req_addr;
            cap_we    <= req_we;
            cap_wdata <= req_wdata;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end

    // keep the last response data visible between responses
    always_ff @(posedge clk or posedge rst)
        if (rst)            rsp_hold <= '0;
        else if (rsp_valid) rsp_hold <= rsp_live;

    imem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (rsp_valid && cap_we && !oob),
        .addr  (cap_addr[ADDR_W-1:0]),
        .wdata (cap_wdata),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_imem_resp.sv
// tb_imem_resp: directed checks of two responder builds (16-bit addr/2 waits, 8-bit addr/0 waits)
module tb_imem_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0, req_we = '0, req_ready, rsp_valid, rsp_err;
    logic [15:0] req_addr [2];
    logic [15:0] req_wdata[2];
    logic [15:0] rsp_data [2];
    int          n_cmp = 0, n_bad = 0;
    int          acc, pulses, dup;
    logic        prev;

    always #5 clk = ~clk;

    imem_resp #(.ADDR_W(16), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_we(req_we[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0])
    );

    imem_resp #(.ADDR_W(8), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_we(req_we[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one access on DUT d; latency is counted in cycles from the acceptance edge
    task automatic access(input int d, input logic [15:0] addr, input logic we,
                          input logic [15:0] wd, input logic [15:0] exp_d, input logic exp_e);
        int n;
        int lat;
        lat = (d == 0) ? 3 : 1;
        @(negedge clk);
        check($sformatf("ready_before%0d", d), 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_addr[d] = addr; req_we[d] = we; req_wdata[d] = wd;
        @(negedge clk);
        req_valid[d] = 1'b0; req_addr[d] = ~addr; req_we[d] = ~we; req_wdata[d] = ~wd;
        n = 1;
        while (!rsp_valid[d] && n < 20) begin
            check($sformatf("busy_ready%0d", d), 32'(req_ready[d]), 32'd0);
            @(negedge clk);
            n++;
        end
        check($sformatf("latency%0d@%h", d, addr), 32'(n), 32'(lat));
        check($sformatf("resp_ready%0d", d), 32'(req_ready[d]), 32'd0);
        check($sformatf("data%0d@%h", d, addr), 32'(rsp_data[d]), 32'(exp_d));
        check($sformatf("err%0d@%h", d, addr), 32'(rsp_err[d]), 32'(exp_e));
        @(negedge clk);
        check($sformatf("pulse_end%0d", d), 32'(rsp_valid[d]), 32'd0);
        check($sformatf("ready_after%0d", d), 32'(req_ready[d]), 32'd1);
        check($sformatf("err_after%0d", d), 32'(rsp_err[d]), 32'd0);
        check($sformatf("data_hold%0d", d), 32'(rsp_data[d]), 32'(exp_d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        req_addr[0] = '0; req_addr[1] = '0; req_wdata[0] = '0; req_wdata[1] = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_valid", 32'(rsp_valid), 32'd0);
            check("rst_err", 32'(rsp_err), 32'd0);
            check("rst_data0", 32'(rsp_data[0]), 32'd0);
            check("rst_data1", 32'(rsp_data[1]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd3);
        check("post_rst_valid", 32'(rsp_valid), 32'd0);

        access(0, 16'h3000, 1'b1, 16'h1234, 16'h1234, 1'b0);
        access(0, 16'h3000, 1'b0, 16'h0000, 16'h1234, 1'b0);
        access(0, 16'h30FF, 1'b1, 16'hA5A5, 16'hA5A5, 1'b0);
        access(0, 16'h3000, 1'b0, 16'h0000, 16'h1234, 1'b0);
        access(0, 16'h30FF, 1'b0, 16'h0000, 16'hA5A5, 1'b0);

        access(1, 16'h0005, 1'b1, 16'h5555, 16'h5555, 1'b0);
        access(1, 16'h0005, 1'b0, 16'h0000, 16'h5555, 1'b0);

        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'h3000;
        acc = 0; pulses = 0; dup = 0; prev = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready[0]) acc++;
            @(negedge clk);
            if (rsp_valid[0]) begin
                pulses++;
                if (prev) dup++;
                check("held_data", 32'(rsp_data[0]), 32'h1234);
            end
            prev = rsp_valid[0];
        end
        req_valid[0] = 1'b0;
        check("held_accepts", 32'(acc), 32'd3);
        check("held_pulses", 32'(pulses), 32'd2);
        check("held_dup", 32'(dup), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid[0]) pulses++;
        end
        check("held_drain_pulses", 32'(pulses), 32'd3);
        check("held_idle_ready", 32'(req_ready[0]), 32'd1);

        access(0, 16'h0010, 1'b1, 16'h1111, 16'h1111, 1'b0);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h0010; req_wdata[0] = 16'hBEEF;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("abort_busy", 32'(req_ready[0]), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_async_ready", 32'(req_ready[0]), 32'd0);
        check("abort_async_valid", 32'(rsp_valid[0]), 32'd0);
        check("abort_async_data", 32'(rsp_data[0]), 32'd0);
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (rsp_valid[0]) pulses++;
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid[0]) pulses++;
        end
        check("abort_no_rsp", 32'(pulses), 32'd0);
        access(0, 16'h0010, 1'b0, 16'h0000, 16'h1111, 1'b0);

        access(1, 16'h0000, 1'b1, 16'h0AAA, 16'h0AAA, 1'b0);
`ifdef IMEM_BOUNDS_CHECK_EN
        access(1, 16'h0100, 1'b1, 16'hCAFE, 16'h0000, 1'b1);
        access(1, 16'h0000, 1'b0, 16'h0000, 16'h0AAA, 1'b0);
`else
        access(1, 16'h0100, 1'b1, 16'hCAFE, 16'hCAFE, 1'b0);
        access(1, 16'h0000, 1'b0, 16'h0000, 16'hCAFE, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
